// File: rtl/gumnut_pkg.sv
// Gumnut instruction encoding: opcode prefix constants and the decoded field bundle.
// Shared by every decoder that looks at an 18-bit Gumnut instruction word.
package gumnut_pkg;

    // Opcode prefixes, matched MSB-first; shortest prefix wins.
    localparam logic [0:0] OP_ALU_IMM = 1'b0;
    localparam logic [1:0] OP_MEM     = 2'b10;
    localparam logic [2:0] OP_SHIFT   = 3'b110;
    localparam logic [3:0] OP_ALU_REG = 4'b1110;
    localparam logic [4:0] OP_JUMP    = 5'b11110;
    localparam logic [5:0] OP_BRANCH  = 6'b111110;
    localparam logic [6:0] OP_MISC    = 7'b1111110;
    localparam logic [6:0] OP_ILLEGAL = 7'b1111111;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  func;
        logic [11:0] addr;
        logic [7:0]  disp;
        logic [2:0]  rs;
        logic [2:0]  rs2;
        logic [2:0]  rd;
        logic [7:0]  immed;
        logic [2:0]  count;
    } inst_fields_t;

endpackage

// File: rtl/ir_decode.sv
// Combinational Gumnut field decoder: inst[17:0] -> field bundle plus illegal flag.
// Zero latency, no handshake; func is always driven to a known value.
module ir_decode
    import gumnut_pkg::*;
(
    input  logic [17:0]  inst,
    output inst_fields_t fields,
    output logic         illegal
);

    logic [6:0] op;

    assign op = inst[17:11];

    always_comb begin
        fields       = '0;
        illegal      = 1'b0;
        fields.op    = op;
        fields.addr  = inst[11:0];
        fields.disp  = inst[7:0];
        fields.rs    = inst[10:8];
        fields.rs2   = inst[7:5];
        fields.rd    = inst[13:11];
        fields.immed = inst[7:0];
        fields.count = inst[7:5];

        if (op[6] == OP_ALU_IMM) begin
            fields.func = inst[16:14];
        end else if (op[6:5] == OP_MEM) begin
            fields.func = {1'b0, inst[15:14]};
        end else if (op[6:4] == OP_SHIFT) begin
            fields.func = {1'b0, inst[1:0]};
        end else if (op[6:3] == OP_ALU_REG) begin
            fields.func = inst[2:0];
        end else if (op[6:2] == OP_JUMP) begin
            fields.func = {2'b00, inst[12]};
        end else if (op[6:1] == OP_BRANCH) begin
            fields.func = {1'b0, inst[11:10]};
        end else if (op == OP_MISC) begin
            fields.func = inst[10:8];
        end else begin
            // Only OP_ILLEGAL reaches here.
            fields.func = 3'b000;
            illegal     = 1'b1;
        end
    end

endmodule

// File: rtl/ir_queue.sv
// Circular instruction queue (DEPTH entries, PC-tagged) with decoded head fields.
// Fetch->decode latency 1 cycle, no bypass; in_ready drops when full, no pop-to-push pass-through.
module ir_queue
    import gumnut_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 12,
    parameter int INST_W = 18
) (
    input  logic                       clkg,
    input  logic                       rst,
    input  logic                       cen,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [PC_W-1:0]            pc_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            pc_o,
    output logic [6:0]                 op_o,
    output logic [2:0]                 func_o,
    output logic [11:0]                addr_o,
    output logic [7:0]                 disp_o,
    output logic [2:0]                 rs_o,
    output logic [2:0]                 rs2_o,
    output logic [2:0]                 rd_o,
    output logic [7:0]                 immed_o,
    output logic [2:0]                 count_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [PC_W-1:0]   pc_mem_d   [DEPTH];

    logic         push;
    logic         pop;
    inst_fields_t head_fields;
    logic         head_illegal;

    // Handshakes depend on state only, so a pop never frees a slot for the same edge.
    assign in_ready  = (level_q < DEPTH_L);
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready & cen & ~flush;
    assign pop       = out_valid & out_ready & cen & ~flush;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        level_d    = level_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        if (cen) begin
            if (flush) begin
                head_d  = '0;
                tail_d  = '0;
                level_d = '0;
            end else begin
                if (push) begin
                    inst_mem_d[tail_q] = inst_i;
                    pc_mem_d[tail_q]   = pc_i;
                    tail_d             = tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   level_d = level_q + LVL_W'(1);
                    2'b01:   level_d = level_q - LVL_W'(1);
                    default: level_d = level_q;
                endcase
            end
        end
    end

    always_ff @(posedge clkg) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    // Storage is not reset; out_valid masks stale contents.
    always_ff @(posedge clkg) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

    ir_decode u_decode (
        .inst    (inst_mem_q[head_q][17:0]),
        .fields  (head_fields),
        .illegal (head_illegal)
    );

    assign level_o   = level_q;
    assign pc_o      = out_valid ? pc_mem_q[head_q]  : '0;
    assign op_o      = out_valid ? head_fields.op    : '0;
    assign func_o    = out_valid ? head_fields.func  : '0;
    assign addr_o    = out_valid ? head_fields.addr  : '0;
    assign disp_o    = out_valid ? head_fields.disp  : '0;
    assign rs_o      = out_valid ? head_fields.rs    : '0;
    assign rs2_o     = out_valid ? head_fields.rs2   : '0;
    assign rd_o      = out_valid ? head_fields.rd    : '0;
    assign immed_o   = out_valid ? head_fields.immed : '0;
    assign count_o   = out_valid ? head_fields.count : '0;
    assign illegal_o = out_valid & head_illegal;

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue: decode table, full/wrap, simultaneous push/pop, flush, cen hold, reset.
module tb_ir_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 12;

    logic        clkg = 1'b0;
    logic        rst, cen, flush, in_valid, out_ready;
    logic        in_ready, out_valid, illegal_o;
    logic [17:0] inst_i;
    logic [11:0] pc_i, pc_o, addr_o;
    logic [6:0]  op_o;
    logic [2:0]  func_o, rs_o, rs2_o, rd_o, count_o;
    logic [7:0]  disp_o, immed_o;
    logic [2:0]  level_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clkg = ~clkg;

    ir_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(18)) dut (
        .clkg      (clkg),
        .rst       (rst),
        .cen       (cen),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst_i    (inst_i),
        .pc_i      (pc_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_o      (pc_o),
        .op_o      (op_o),
        .func_o    (func_o),
        .addr_o    (addr_o),
        .disp_o    (disp_o),
        .rs_o      (rs_o),
        .rs2_o     (rs2_o),
        .rd_o      (rd_o),
        .immed_o   (immed_o),
        .count_o   (count_o),
        .illegal_o (illegal_o),
        .level_o   (level_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clkg);
        #1;
    endtask

    task automatic push_one(input logic [17:0] inst, input logic [11:0] pc);
        in_valid = 1'b1;
        inst_i   = inst;
        pc_i     = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_level"},   32'(level_o),   32'd0);
        chk({tag, "_inrdy"},   32'(in_ready),  32'd1);
        chk({tag, "_outvld"},  32'(out_valid), 32'd0);
        chk({tag, "_pc"},      32'(pc_o),      32'd0);
        chk({tag, "_op"},      32'(op_o),      32'd0);
        chk({tag, "_func"},    32'(func_o),    32'd0);
        chk({tag, "_rs"},      32'(rs_o),      32'd0);
        chk({tag, "_immed"},   32'(immed_o),   32'd0);
        chk({tag, "_illegal"}, 32'(illegal_o), 32'd0);
    endtask

    // Decode vectors: instruction, expected op, func, rs, illegal.
    logic [17:0] dv_inst [8] = '{18'h05305, 18'h3F500, 18'h3F800, 18'h30003,
                                 18'h3D000, 18'h2C000, 18'h38006, 18'h3E800};
    logic [6:0]  dv_op   [8] = '{7'h0A, 7'h7E, 7'h7F, 7'h60, 7'h7A, 7'h58, 7'h70, 7'h7D};
    logic [2:0]  dv_func [8] = '{3'd1, 3'd5, 3'd0, 3'd3, 3'd1, 3'd3, 3'd6, 3'd2};
    logic [2:0]  dv_rs   [8] = '{3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic        dv_ill  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        rst = 1'b1; cen = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst_i = '0; pc_i = '0;
        step(); step();
        rst = 1'b0;
        check_idle("reset");

        // First instruction: full field check, 1-cycle latency.
        push_one(18'h05305, 12'h010);
        chk("t1_outvld", 32'(out_valid), 32'd1);
        chk("t1_rd",     32'(rd_o),      32'd2);
        chk("t1_immed",  32'(immed_o),   32'h05);
        chk("t1_pc",     32'(pc_o),      32'h010);
        chk("t1_level",  32'(level_o),   32'd1);
        chk("t1_addr",   32'(addr_o),    32'h305);
        chk("t1_disp",   32'(disp_o),    32'h05);
        chk("t1_rs2",    32'(rs2_o),     32'd0);
        chk("t1_count",  32'(count_o),   32'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t1_drained", 32'(level_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            push_one(dv_inst[i], 12'(i));
            chk($sformatf("dec%0d_op", i),   32'(op_o),      32'(dv_op[i]));
            chk($sformatf("dec%0d_func", i), 32'(func_o),    32'(dv_func[i]));
            chk($sformatf("dec%0d_rs", i),   32'(rs_o),      32'(dv_rs[i]));
            chk($sformatf("dec%0d_ill", i),  32'(illegal_o), 32'(dv_ill[i]));
            out_ready = 1'b1; step(); out_ready = 1'b0;
        end

        // Fill to full, fifth held, then drain with wrap.
        for (int i = 0; i < 4; i++) push_one(18'h00100 + 18'(i), 12'(i));
        chk("full_level", 32'(level_o),  32'd4);
        chk("full_inrdy", 32'(in_ready), 32'd0);
        in_valid = 1'b1; inst_i = 18'h00104; pc_i = 12'd4;
        step();
        chk("held_level", 32'(level_o), 32'd4);
        chk("held_head",  32'(pc_o),    32'd0);
        out_ready = 1'b1;
        step();
        chk("pop0_pc",    32'(pc_o),     32'd1);
        chk("pop0_level", 32'(level_o),  32'd3);
        chk("pop0_inrdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("pop1_pc",    32'(pc_o),    32'd2);
        chk("pop1_level", 32'(level_o), 32'd3);
        step();
        chk("pop2_pc",    32'(pc_o),    32'd3);
        step();
        chk("pop3_pc",    32'(pc_o),    32'd4);
        chk("pop3_level", 32'(level_o), 32'd1);
        chk("pop3_inst",  32'(immed_o), 32'h04);
        step();
        out_ready = 1'b0;
        chk("drain_vld",  32'(out_valid), 32'd0);

        // Simultaneous push and pop at level 2.
        push_one(18'h00120, 12'h020);
        push_one(18'h00121, 12'h021);
        in_valid = 1'b1; inst_i = 18'h00122; pc_i = 12'h022; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pp_level", 32'(level_o), 32'd2);
        chk("pp_head",  32'(pc_o),    32'h021);
        step();
        chk("pp_tail",  32'(pc_o),    32'h022);
        step();
        out_ready = 1'b0;
        chk("pp_empty", 32'(level_o), 32'd0);

        // Flush at level 3 with push and pop both requested.
        push_one(18'h00130, 12'h030);
        push_one(18'h00131, 12'h031);
        push_one(18'h00132, 12'h032);
        chk("pre_flush_level", 32'(level_o), 32'd3);
        flush = 1'b1; in_valid = 1'b1; inst_i = 18'h3F500; pc_i = 12'h033; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_idle("flush");
        push_one(18'h00140, 12'h040);
        chk("post_flush_pc",    32'(pc_o),    32'h040);
        chk("post_flush_level", 32'(level_o), 32'd1);
        push_one(18'h00141, 12'h041);

        // Clock enable low: nothing moves.
        cen = 1'b0; in_valid = 1'b1; inst_i = 18'h00150; pc_i = 12'h050; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("cen%0d_level", i), 32'(level_o), 32'd2);
            chk($sformatf("cen%0d_pc", i),    32'(pc_o),    32'h040);
        end
        cen = 1'b1; in_valid = 1'b0; out_ready = 1'b0;

        // Reset mid-stream at level 2.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midrst");
        push_one(18'h00160, 12'h060);
        chk("post_rst_pc",    32'(pc_o),    32'h060);
        chk("post_rst_level", 32'(level_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
